// File: rtl/wb_regfile_writer.sv
// Write-back stage: commits MEM/WB results into the vector and scalar banks.
// Optional same-cycle read bypass enabled by defining WB_BYPASS_EN.
module wb_regfile_writer #(
    parameter int NREG  = 8,
    parameter int AW    = $clog2(NREG),
    parameter int VW    = 32,
    parameter int SW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_in,
    input  logic             sel_wb_in,
    input  logic             reg_wrv_in,
    input  logic             reg_wrs_in,
    input  logic [VW-1:0]    MEM_in,
    input  logic [VW-1:0]    DATA_in,
    input  logic [AW-1:0]    dir_dest_in,
    input  logic [SW-1:0]    data_wrs_in,
    input  logic [AW-1:0]    rd_va_addr,
    input  logic [AW-1:0]    rd_vb_addr,
    input  logic [AW-1:0]    rd_s_addr,
    output logic [VW-1:0]    rd_va_data,
    output logic [VW-1:0]    rd_vb_data,
    output logic [SW-1:0]    rd_s_data,
    output logic             fwd_valid,
    output logic [AW-1:0]    fwd_dest,
    output logic [VW-1:0]    fwd_data,
    output logic [CNT_W-1:0] wb_count
);

    logic [VW-1:0]    vreg_q [NREG];
    logic [SW-1:0]    sreg_q [NREG];
    logic             fwd_valid_q;
    logic [AW-1:0]    fwd_dest_q;
    logic [VW-1:0]    fwd_data_q;
    logic [CNT_W-1:0] wb_count_q;
    logic [CNT_W-1:0] wb_count_d;

    logic [VW-1:0] wb_data;
    logic          commit_v;
    logic          commit_s;

    assign wb_data  = sel_wb_in ? MEM_in : DATA_in;
    assign commit_v = reg_wrv_in & ~stall_in;
    assign commit_s = reg_wrs_in & ~stall_in;

    // Counter saturates at all-ones instead of wrapping.
    always_comb begin
        wb_count_d = wb_count_q;
        if ((commit_v | commit_s) && !(&wb_count_q)) begin
            wb_count_d = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                vreg_q[i] <= '0;
                sreg_q[i] <= '0;
            end
            fwd_valid_q <= 1'b0;
            fwd_dest_q  <= '0;
            fwd_data_q  <= '0;
            wb_count_q  <= '0;
        end else begin
            if (commit_v) begin
                vreg_q[dir_dest_in] <= wb_data;
                fwd_dest_q          <= dir_dest_in;
                fwd_data_q          <= wb_data;
            end
            if (commit_s) begin
                sreg_q[dir_dest_in] <= data_wrs_in;
            end
            fwd_valid_q <= commit_v;
            wb_count_q  <= wb_count_d;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rd_va_data = vreg_q[rd_va_addr];
        rd_vb_data = vreg_q[rd_vb_addr];
        rd_s_data  = sreg_q[rd_s_addr];
        if (commit_v && rd_va_addr == dir_dest_in) begin
            rd_va_data = wb_data;
        end
        if (commit_v && rd_vb_addr == dir_dest_in) begin
            rd_vb_data = wb_data;
        end
        if (commit_s && rd_s_addr == dir_dest_in) begin
            rd_s_data = data_wrs_in;
        end
    end
`else
    assign rd_va_data = vreg_q[rd_va_addr];
    assign rd_vb_data = vreg_q[rd_vb_addr];
    assign rd_s_data  = sreg_q[rd_s_addr];
`endif

    assign fwd_valid = fwd_valid_q;
    assign fwd_dest  = fwd_dest_q;
    assign fwd_data  = fwd_data_q;
    assign wb_count  = wb_count_q;

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Directed bench for wb_regfile_writer with a queue of expected post-edge results.
// A second instance with CNT_W=4 shares the stimulus to cover counter saturation.
module tb_wb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in, sel_wb_in, reg_wrv_in, reg_wrs_in;
    logic [31:0] MEM_in, DATA_in;
    logic [2:0]  dir_dest_in;
    logic [7:0]  data_wrs_in;
    logic [2:0]  rd_va_addr, rd_vb_addr, rd_s_addr;

    logic [31:0] rd_va_data, rd_vb_data, fwd_data;
    logic [7:0]  rd_s_data;
    logic        fwd_valid;
    logic [2:0]  fwd_dest;
    logic [15:0] wb_count;

    logic [31:0] rd_va_data4, rd_vb_data4, fwd_data4;
    logic [7:0]  rd_s_data4;
    logic        fwd_valid4;
    logic [2:0]  fwd_dest4;
    logic [3:0]  wb_count4;

    always #5 clk = ~clk;

    wb_regfile_writer dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .sel_wb_in(sel_wb_in), .reg_wrv_in(reg_wrv_in),
        .reg_wrs_in(reg_wrs_in), .MEM_in(MEM_in), .DATA_in(DATA_in),
        .dir_dest_in(dir_dest_in), .data_wrs_in(data_wrs_in),
        .rd_va_addr(rd_va_addr), .rd_vb_addr(rd_vb_addr),
        .rd_s_addr(rd_s_addr), .rd_va_data(rd_va_data),
        .rd_vb_data(rd_vb_data), .rd_s_data(rd_s_data),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .wb_count(wb_count)
    );

    wb_regfile_writer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .sel_wb_in(sel_wb_in), .reg_wrv_in(reg_wrv_in),
        .reg_wrs_in(reg_wrs_in), .MEM_in(MEM_in), .DATA_in(DATA_in),
        .dir_dest_in(dir_dest_in), .data_wrs_in(data_wrs_in),
        .rd_va_addr(rd_va_addr), .rd_vb_addr(rd_vb_addr),
        .rd_s_addr(rd_s_addr), .rd_va_data(rd_va_data4),
        .rd_vb_data(rd_vb_data4), .rd_s_data(rd_s_data4),
        .fwd_valid(fwd_valid4), .fwd_dest(fwd_dest4),
        .fwd_data(fwd_data4), .wb_count(wb_count4)
    );

    typedef struct packed {
        logic        fv;
        logic [2:0]  fd;
        logic [31:0] fdat;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mv [8];
    logic [7:0]  ms [8];
    logic [2:0]  m_fd;
    logic [31:0] m_fdat;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = '0;
            ms[i] = '0;
        end
        m_fd = '0; m_fdat = '0; m_cnt = '0; m_cnt4 = '0;
        sb.delete();
    endtask

    task automatic idle();
        stall_in = 0; sel_wb_in = 0; reg_wrv_in = 0; reg_wrs_in = 0;
        MEM_in = '0; DATA_in = '0; dir_dest_in = '0; data_wrs_in = '0;
    endtask

    // Drive one MEM/WB bundle; model the effect and queue the expected result.
    task automatic drive(input logic sel, input logic wrv, input logic wrs,
                         input logic stall, input logic [31:0] mem,
                         input logic [31:0] dat, input logic [2:0] dest,
                         input logic [7:0] ws);
        exp_t        e;
        logic        cv, cs;
        logic [31:0] wd;
        stall_in = stall; sel_wb_in = sel; reg_wrv_in = wrv;
        reg_wrs_in = wrs; MEM_in = mem; DATA_in = dat;
        dir_dest_in = dest; data_wrs_in = ws;
        wd = sel ? mem : dat;
        cv = wrv & ~stall;
        cs = wrs & ~stall;
        if (cv) begin
            mv[dest] = wd;
            m_fd = dest;
            m_fdat = wd;
        end
        if (cs) ms[dest] = ws;
        if (cv | cs) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
        end
        e.fv = cv; e.fd = m_fd; e.fdat = m_fdat;
        e.cnt = m_cnt; e.cnt4 = m_cnt4;
        sb.push_back(e);
    endtask

    task automatic commit(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_fv"}, 32'(fwd_valid), 32'(e.fv));
            chk({tag, "_fd"}, 32'(fwd_dest), 32'(e.fd));
            chk({tag, "_fdat"}, fwd_data, e.fdat);
            chk({tag, "_cnt"}, 32'(wb_count), 32'(e.cnt));
            chk({tag, "_cnt4"}, 32'(wb_count4), 32'(e.cnt4));
            chk({tag, "_fdat4"}, fwd_data4, e.fdat);
            chk({tag, "_fv4"}, 32'(fwd_valid4), 32'(e.fv));
            chk({tag, "_fd4"}, 32'(fwd_dest4), 32'(e.fd));
        end
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [2:0] b, input logic [2:0] s);
        rd_va_addr = a; rd_vb_addr = b; rd_s_addr = s;
        #1;
        chk({tag, "_va"}, rd_va_data, mv[a]);
        chk({tag, "_vb"}, rd_vb_data, mv[b]);
        chk({tag, "_s"}, 32'(rd_s_data), 32'(ms[s]));
        chk({tag, "_va4"}, rd_va_data4, mv[a]);
        chk({tag, "_vb4"}, rd_vb_data4, mv[b]);
        chk({tag, "_s4"}, 32'(rd_s_data4), 32'(ms[s]));
    endtask

    initial begin
        logic [31:0] old_v;
        logic [7:0]  old_s;
        logic [31:0] ev;
        logic [7:0]  es;
        rst_n = 0;
        idle();
        rd_va_addr = 0; rd_vb_addr = 0; rd_s_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rd("rst0", 3'd5, 3'd3, 3'd3);
        chk("rst0_fv", 32'(fwd_valid), 32'd0);
        chk("rst0_cnt", 32'(wb_count), 32'd0);
        rst_n = 1;

        drive(1, 1, 0, 0, 32'hDEADBEEF, 32'h12345678, 3'd5, 8'h00);
        commit("mem5");
        rd("mem5", 3'd5, 3'd0, 3'd5);
        drive(0, 1, 0, 0, 32'hDEADBEEF, 32'h12345678, 3'd5, 8'h00);
        commit("alu5");
        rd("alu5", 3'd5, 3'd5, 3'd0);

        drive(0, 1, 1, 0, 32'h0, 32'hCAFEF00D, 3'd3, 8'hA5);
        commit("both3");
        rd("both3", 3'd3, 3'd5, 3'd3);

        drive(1, 1, 1, 1, 32'h55555555, 32'h0, 3'd2, 8'h77);
        commit("stall2");
        rd("stall2", 3'd2, 3'd3, 3'd2);

        drive(0, 0, 1, 0, 32'h0, 32'h0, 3'd6, 8'h3C);
        commit("sonly6");
        rd("sonly6", 3'd6, 3'd5, 3'd6);

        drive(1, 1, 1, 0, 32'h80000001, 32'h0, 3'd0, 8'hFF);
        commit("reg0");
        rd("reg0", 3'd0, 3'd3, 3'd0);

        rd_va_addr = 3'd7; rd_vb_addr = 3'd7; rd_s_addr = 3'd7;
        old_v = mv[7];
        old_s = ms[7];
        drive(0, 1, 1, 0, 32'h0, 32'h0F0F0F0F, 3'd7, 8'h5A);
        #1;
`ifdef WB_BYPASS_EN
        ev = 32'h0F0F0F0F;
        es = 8'h5A;
`else
        ev = old_v;
        es = old_s;
`endif
        chk("byp_va", rd_va_data, ev);
        chk("byp_vb", rd_vb_data, ev);
        chk("byp_s", 32'(rd_s_data), 32'(es));
        commit("byp7");
        rd("byp7", 3'd7, 3'd7, 3'd7);

        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                  1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  8'($urandom));
            commit("burst");
        end
        chk("sat4", 32'(wb_count4), 32'd15);
        rd("burst_a", 3'd1, 3'd2, 3'd4);
        rd("burst_b", 3'd6, 3'd7, 3'd5);

        #2;
        rst_n = 0;
        #1;
        model_reset();
        rd("midrst", 3'd7, 3'd5, 3'd3);
        chk("midrst_fv", 32'(fwd_valid), 32'd0);
        chk("midrst_fd", 32'(fwd_dest), 32'd0);
        chk("midrst_fdat", fwd_data, 32'd0);
        chk("midrst_cnt", 32'(wb_count), 32'd0);
        chk("midrst_cnt4", 32'(wb_count4), 32'd0);
        @(negedge clk);
        rst_n = 1;

        drive(1, 1, 0, 0, 32'h0BADF00D, 32'h0, 3'd4, 8'h00);
        commit("resume");
        rd("resume", 3'd4, 3'd5, 3'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
